// File: rtl/panda_pkg.sv
// Shared types for the Panda execute path.
package panda_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE, MDU_CALC, MDU_DONE
  } mdu_state_e;

  function automatic logic mdu_is_div(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

endpackage

// File: rtl/panda_alu.sv
// Single-cycle integer ALU, purely combinational.
module panda_alu
  import panda_pkg::*;
#(
  parameter int Width = 32
) (
  input  alu_op_e            operator_i,
  input  logic [Width-1:0]   operand_a_i,
  input  logic [Width-1:0]   operand_b_i,
  output logic [Width-1:0]   result_o
);

  localparam int ShW = $clog2(Width);

  logic [ShW-1:0] shamt;
  assign shamt = operand_b_i[ShW-1:0];

  // Operation select.
  always_comb begin
    result_o = '0;
    case (operator_i)
      ALU_ADD:  result_o = operand_a_i + operand_b_i;
      ALU_SUB:  result_o = operand_a_i - operand_b_i;
      ALU_AND:  result_o = operand_a_i & operand_b_i;
      ALU_OR:   result_o = operand_a_i | operand_b_i;
      ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
      ALU_SLL:  result_o = operand_a_i << shamt;
      ALU_SRL:  result_o = operand_a_i >> shamt;
      ALU_SRA:  result_o = $signed(operand_a_i) >>> shamt;
      ALU_SLT:  result_o = {{(Width-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      ALU_SLTU: result_o = {{(Width-1){1'b0}}, operand_a_i < operand_b_i};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/panda_mdu.sv
// Iterative radix-2 multiply/divide unit working on operand magnitudes.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   MDU_IDLE | no op in flight, waiting for start_i
//   MDU_CALC | one shift-add / restoring-divide step per edge, Width steps
//   MDU_DONE | sign-corrected result on result_o, leave when ack_i
module panda_mdu
  import panda_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               start_i,
  input  mdu_op_e            op_i,
  input  logic [Width-1:0]   operand_a_i,
  input  logic [Width-1:0]   operand_b_i,
  input  logic               ack_i,
  output logic [Width-1:0]   result_o,
  output logic               done_o,
  output logic               busy_o
);

  localparam int CntW = $clog2(Width);
  localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

  mdu_state_e           state_q;
  mdu_op_e              op_q;
  logic [CntW-1:0]      count_q;
  logic [2*Width-1:0]   acc_q;
  logic [Width-1:0]     b_q;
  logic                 a_neg_q, b_neg_q, zero_q, ovf_q;

  logic                 a_neg, b_neg;
  logic [Width-1:0]     a_mag, b_mag;
  logic [Width:0]       mul_sum, rem_sh, rem_diff;
  logic [2*Width-1:0]   mul_next, div_next, prod;
  logic [Width-1:0]     quo_f, rem_f;

  // Signedness and magnitudes of the incoming operands.
  always_comb begin
    a_neg = (op_i inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM}) && operand_a_i[Width-1];
    b_neg = (op_i inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM}) && operand_b_i[Width-1];
    a_mag = a_neg ? -operand_a_i : operand_a_i;
    b_mag = b_neg ? -operand_b_i : operand_b_i;
  end

  // One multiply step (add then shift right) and one restoring divide step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[Width-1:1]};
    rem_sh   = {acc_q[2*Width-1:Width], acc_q[Width-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    div_next = {rem_diff[Width] ? rem_sh[Width-1:0] : rem_diff[Width-1:0],
                acc_q[Width-2:0], ~rem_diff[Width]};
  end

  // Sign correction and divide special-case overrides.
  always_comb begin
    prod  = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo_f = (a_neg_q ^ b_neg_q) ? -acc_q[Width-1:0] : acc_q[Width-1:0];
    rem_f = a_neg_q ? -acc_q[2*Width-1:Width] : acc_q[2*Width-1:Width];
    if (zero_q) begin
      quo_f = '1;
    end else if (ovf_q) begin
      quo_f = MinVal;
      rem_f = '0;
    end
    case (op_q)
      MDU_MUL:                        result_o = prod[Width-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: result_o = prod[2*Width-1:Width];
      MDU_DIV, MDU_DIVU:              result_o = quo_f;
      default:                        result_o = rem_f;
    endcase
  end

  assign done_o = (state_q == MDU_DONE);
  assign busy_o = (state_q != MDU_IDLE);

  // Control FSM with operand latch, step counter and accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MDU_IDLE;
      op_q    <= MDU_MUL;
      count_q <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= MDU_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start_i) begin
            state_q <= MDU_CALC;
            count_q <= '0;
            op_q    <= op_i;
            acc_q   <= {{Width{1'b0}}, a_mag};
            b_q     <= b_mag;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            zero_q  <= (operand_b_i == '0);
            ovf_q   <= (op_i inside {MDU_DIV, MDU_REM}) &&
                       (operand_a_i == MinVal) && (operand_b_i == '1);
          end
        end
        MDU_CALC: begin
          acc_q   <= mdu_is_div(op_q) ? div_next : mul_next;
          count_q <= count_q + 1'b1;
          if (count_q == CntW'(Width-1)) begin
            state_q <= MDU_DONE;
            count_q <= '0;
          end
        end
        MDU_DONE: begin
          if (ack_i) state_q <= MDU_IDLE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/panda_ex_stage_mc.sv
// Multi-cycle execute stage: ALU in one cycle, optional iterative MDU,
// elastic valid/ready output register towards EX/MEM.
module panda_ex_stage_mc
  import panda_pkg::*;
#(
  parameter int Width = 32,
  parameter bit MduEn = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  alu_op_e            alu_operator_i,
  input  logic               mdu_sel_i,
  input  mdu_op_e            mdu_op_i,
  input  logic [Width-1:0]   operand_a_i,
  input  logic [Width-1:0]   operand_b_i,
  input  logic [4:0]         rd_addr_i,
  input  logic               rd_we_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [Width-1:0]   result_o,
  output logic [4:0]         rd_addr_o,
  output logic               rd_we_o,
  output logic               busy_o
);

  logic               valid_q, rd_we_q, pend_rd_we_q;
  logic [Width-1:0]   result_q;
  logic [4:0]         rd_addr_q, pend_rd_addr_q;
  logic               out_room, accept, mdu_start, alu_load, mdu_load;
  logic               mdu_busy, mdu_done;
  logic [Width-1:0]   alu_result, mdu_result;

  assign out_room  = !valid_q || ready_i;
  assign ready_o   = !mdu_busy && out_room;
  assign accept    = valid_i && ready_o && !flush_i;
  assign mdu_start = accept && MduEn && mdu_sel_i;
  assign alu_load  = accept && !(MduEn && mdu_sel_i);
  assign mdu_load  = mdu_done && out_room && !flush_i;

  panda_alu #(.Width(Width)) u_alu (
    .operator_i  (alu_operator_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .result_o    (alu_result)
  );

  if (MduEn) begin : g_mdu
    panda_mdu #(.Width(Width)) u_mdu (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .start_i     (mdu_start),
      .op_i        (mdu_op_i),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .ack_i       (out_room),
      .result_o    (mdu_result),
      .done_o      (mdu_done),
      .busy_o      (mdu_busy)
    );
  end else begin : g_no_mdu
    assign mdu_result = '0;
    assign mdu_done   = 1'b0;
    assign mdu_busy   = 1'b0;
  end

  // Output register plus destination info held while the MDU iterates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q        <= 1'b0;
      result_q       <= '0;
      rd_addr_q      <= '0;
      rd_we_q        <= 1'b0;
      pend_rd_addr_q <= '0;
      pend_rd_we_q   <= 1'b0;
    end else begin
      if (mdu_start) begin
        pend_rd_addr_q <= rd_addr_i;
        pend_rd_we_q   <= rd_we_i;
      end
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (alu_load) begin
        valid_q   <= 1'b1;
        result_q  <= alu_result;
        rd_addr_q <= rd_addr_i;
        rd_we_q   <= rd_we_i;
      end else if (mdu_load) begin
        valid_q   <= 1'b1;
        result_q  <= mdu_result;
        rd_addr_q <= pend_rd_addr_q;
        rd_we_q   <= pend_rd_we_q;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_we_o   = rd_we_q;
  assign busy_o    = mdu_busy;

endmodule

// File: tb/tb_panda_ex_stage_mc.sv
// Directed bench for panda_ex_stage_mc (Width = 32, MDU present).
module tb_panda_ex_stage_mc;
  import panda_pkg::*;

  logic        clk_i, rst_ni, flush_i, valid_i, ready_o, mdu_sel_i;
  alu_op_e     alu_operator_i;
  mdu_op_e     mdu_op_i;
  logic [31:0] operand_a_i, operand_b_i, result_o;
  logic [4:0]  rd_addr_i, rd_addr_o;
  logic        rd_we_i, valid_o, ready_i, rd_we_o, busy_o;

  int n_chk = 0;
  int n_bad = 0;

  panda_ex_stage_mc #(.Width(32), .MduEn(1'b1)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .alu_operator_i (alu_operator_i),
    .mdu_sel_i      (mdu_sel_i),
    .mdu_op_i       (mdu_op_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .rd_addr_i      (rd_addr_i),
    .rd_we_i        (rd_we_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .result_o       (result_o),
    .rd_addr_o      (rd_addr_o),
    .rd_we_o        (rd_we_o),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    valid_i = 1'b1; mdu_sel_i = 1'b0; alu_operator_i = op;
    operand_a_i = a; operand_b_i = b; rd_addr_i = rd; rd_we_i = 1'b1;
  endtask

  task automatic drive_mdu(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    valid_i = 1'b1; mdu_sel_i = 1'b1; mdu_op_i = op;
    operand_a_i = a; operand_b_i = b; rd_addr_i = rd; rd_we_i = 1'b1;
  endtask

  task automatic run_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
    drive_alu(op, a, b, 5'd2);
    chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    chk({tag, "_vld"}, 32'(valid_o), 32'd1);
    chk({tag, "_res"}, result_o, exp);
  endtask

  // Issues one MDU op with ready_i = 1 and checks latency, stall length and result.
  task automatic run_mdu(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
    int edges, low;
    drive_mdu(op, a, b, 5'd9);
    chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0; mdu_sel_i = 1'b0;
    edges = 0; low = 0;
    while (!valid_o && edges < 40) begin
      if (!ready_o) low++;
      tick();
      edges++;
    end
    chk({tag, "_lat"}, 32'(edges), 32'd33);
    chk({tag, "_stall"}, 32'(low), 32'd33);
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_rd"}, 32'(rd_addr_o), 32'd9);
    tick();
    chk({tag, "_drop"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    logic seen;
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; mdu_sel_i = 1'b0;
    alu_operator_i = ALU_ADD; mdu_op_i = MDU_MUL;
    operand_a_i = '0; operand_b_i = '0; rd_addr_i = '0; rd_we_i = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    chk("rst_we", 32'(rd_we_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();

    // ALU back-to-back
    drive_alu(ALU_ADD, 32'd5, 32'd7, 5'd3);
    tick();
    chk("add1_vld", 32'(valid_o), 32'd1);
    chk("add1_res", result_o, 32'd12);
    chk("add1_rd", 32'(rd_addr_o), 32'd3);
    chk("add1_we", 32'(rd_we_o), 32'd1);
    chk("add1_rdy", 32'(ready_o), 32'd1);
    drive_alu(ALU_ADD, 32'd100, 32'd23, 5'd4);
    tick();
    chk("add2_res", result_o, 32'd123);
    chk("add2_rd", 32'(rd_addr_o), 32'd4);
    valid_i = 1'b0;
    tick();
    chk("add2_drop", 32'(valid_o), 32'd0);
    run_alu(ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, "sub");
    run_alu(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
    run_alu(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
    run_alu(ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");

    // Multiply
    run_mdu(MDU_MUL,    32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, "mul");
    run_mdu(MDU_MULH,   32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, "mulh");
    run_mdu(MDU_MULHU,  32'hFFFF_FFFF, 32'd3, 32'h0000_0002, "mulhu");
    run_mdu(MDU_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu");
    run_mdu(MDU_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_min");
    run_mdu(MDU_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, "mulhu_big");

    // Divide, remainder, divide by zero, signed overflow
    run_mdu(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
    run_mdu(MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
    run_mdu(MDU_DIVU, 32'd100, 32'd7, 32'd14, "divu");
    run_mdu(MDU_REMU, 32'd100, 32'd7, 32'd2, "remu");
    run_mdu(MDU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, "divu0");
    run_mdu(MDU_REM,  32'd9, 32'd0, 32'd9, "rem0");
    run_mdu(MDU_DIV,  32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, "div0_neg");
    run_mdu(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_mdu(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");

    // Backpressure: ALU result held, then DIV accepted as it drains
    ready_i = 1'b0;
    drive_alu(ALU_ADD, 32'd1, 32'd2, 5'd4);
    tick();
    valid_i = 1'b0;
    chk("bp_alu_vld", 32'(valid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_alu_hold", result_o, 32'd3);
      chk("bp_alu_rdy", 32'(ready_o), 32'd0);
    end
    drive_mdu(MDU_DIVU, 32'd100, 32'd7, 5'd11);
    ready_i = 1'b1;
    #1;
    chk("bp_rdy_up", 32'(ready_o), 32'd1);
    tick();
    ready_i = 1'b0; valid_i = 1'b0; mdu_sel_i = 1'b0;
    chk("bp_alu_gone", 32'(valid_o), 32'd0);
    chk("bp_div_busy", 32'(busy_o), 32'd1);
    edges = 0;
    while (!valid_o && edges < 40) begin
      tick();
      edges++;
    end
    chk("bp_div_lat", 32'(edges), 32'd33);
    chk("bp_div_res", result_o, 32'd14);
    chk("bp_div_rd", 32'(rd_addr_o), 32'd11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_div_hold", result_o, 32'd14);
      chk("bp_div_vld", 32'(valid_o), 32'd1);
      chk("bp_div_rdy", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    tick();
    chk("bp_div_drop", 32'(valid_o), 32'd0);

    // Flush mid-DIV
    drive_mdu(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6);
    tick();
    valid_i = 1'b0; mdu_sel_i = 1'b0;
    repeat (10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_busy", 32'(busy_o), 32'd0);
    chk("fl_ready", 32'(ready_o), 32'd1);
    seen = valid_o;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | valid_o;
    end
    chk("fl_no_valid", 32'(seen), 32'd0);

    // Flush blocks accept in the same cycle and drops a pending result
    drive_alu(ALU_ADD, 32'd1, 32'd1, 5'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("fl_no_accept", 32'(valid_o), 32'd0);
    ready_i = 1'b0;
    drive_alu(ALU_ADD, 32'd20, 32'd22, 5'd7);
    tick();
    valid_i = 1'b0;
    chk("fl_pend_res", result_o, 32'd42);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_pend_drop", 32'(valid_o), 32'd0);
    ready_i = 1'b1;
    run_mdu(MDU_MUL, 32'd6, 32'd7, 32'd42, "post_fl_mul");

    // Reset mid-MUL
    drive_mdu(MDU_MUL, 32'hFFFF_FFFF, 32'd3, 5'd8);
    tick();
    valid_i = 1'b0; mdu_sel_i = 1'b0;
    repeat (5) tick();
    rst_ni = 1'b0;
    #1;
    chk("mr_valid", 32'(valid_o), 32'd0);
    chk("mr_result", result_o, 32'd0);
    chk("mr_rd", 32'(rd_addr_o), 32'd0);
    chk("mr_we", 32'(rd_we_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();
    run_mdu(MDU_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, "post_rst_mul");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
